// File: rtl/sprite_blitter.sv
// Parametrised SIZE x SIZE sprite blitter for the 8-bit TFT bus: erases the uncovered part of the old footprint, then draws the new one.
// Optional SPRITE_PINGPONG_EN: animation frames bounce 0..FRAMES-1..0 instead of wrapping.
module sprite_blitter #(
  parameter int unsigned SIZE      = 22,
  parameter int unsigned FRAMES    = 3,
  parameter int unsigned BPP_BYTES = 3,
  parameter int unsigned ANIM_DIV  = 4,
  parameter int unsigned RESET_X   = 5,
  parameter int unsigned RESET_Y   = 5,
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1,
  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE * SIZE) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  input  logic          i_start,
  input  logic [8:0]    i_x,
  input  logic [8:0]    i_y,
  input  logic [1:0]    i_direction,
  input  logic [23:0]   i_fg_color,
  input  logic [23:0]   i_bg_color,
  output logic [FW-1:0] o_rom_frame,
  output logic [AW-1:0] o_rom_addr,
  input  logic          i_rom_bit,
  input  logic          i_tft_busy,
  output logic          o_tft_dc,
  output logic [7:0]    o_tft_data,
  output logic          o_tft_transmit,
  output logic          o_busy,
  output logic          o_done
);

  localparam int unsigned BW = (BPP_BYTES > 1) ? $clog2(BPP_BYTES) : 1;
  localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [8:0] S9 = 9'(SIZE);
  localparam logic [8:0] S1 = 9'(SIZE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_WIN   = 3'd2;
  localparam logic [2:0] S_FETCH = 3'd3;
  localparam logic [2:0] S_PIX   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]    r_state, w_nxt_state;
  logic [8:0]    r_x, r_y, r_ox, r_oy;
  logic [8:0]    r_xmin, r_xmax, r_ymin, r_ymax, r_c, r_r;
  logic [1:0]    r_dir;
  logic [23:0]   r_fg, r_bg;
  logic          r_phase;
  logic [3:0]    r_widx;
  logic [BW-1:0] r_bidx;
  logic [FW-1:0] r_frame;
  logic [DW-1:0] r_dcnt;
  logic          r_tft_dc, r_tft_transmit, r_busy, r_done;
  logic [7:0]    r_tft_data;
  logic [AW-1:0] r_rom_addr;
`ifdef SPRITE_PINGPONG_EN
  logic          r_fdir;
`endif

  logic          w_ready, w_col_end, w_row_end, w_last_byte, w_win_last, w_pix_done;
  logic [8:0]    w_dx, w_dy, w_xmin, w_xmax, w_ymin, w_ymax;
  logic          w_to_draw, w_xstripe, w_ystripe;
  logic [8:0]    w_nc, w_nr, w_sc, w_sr;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_win_byte, w_pix_byte;
  logic [23:0]   w_color;

  assign w_ready     = i_enable && !i_tft_busy && !r_tft_transmit;
  assign w_col_end   = (r_xmin + r_c) == r_xmax;
  assign w_row_end   = (r_ymin + r_r) == r_ymax;
  assign w_pix_done  = w_col_end && w_row_end;
  assign w_last_byte = r_bidx == BW'(BPP_BYTES - 1);
  assign w_win_last  = r_widx == 4'd10;

  assign w_dx      = (r_x > r_ox) ? r_x - r_ox : r_ox - r_x;
  assign w_dy      = (r_y > r_oy) ? r_y - r_oy : r_oy - r_y;
  assign w_xstripe = (r_y == r_oy) && (w_dx != 9'd0) && (w_dx < S9);
  assign w_ystripe = (r_x == r_ox) && (w_dy != 9'd0) && (w_dy < S9);

  // Phase rectangle: only the strip of the old box the new box leaves uncovered.
  always_comb begin
    w_xmin    = r_x;
    w_xmax    = r_x + S1;
    w_ymin    = r_y;
    w_ymax    = r_y + S1;
    w_to_draw = 1'b1;
    if (!r_phase && !((r_x == r_ox) && (r_y == r_oy))) begin
      w_to_draw = 1'b0;
      w_xmin    = r_ox;
      w_xmax    = r_ox + S1;
      w_ymin    = r_oy;
      w_ymax    = r_oy + S1;
      if (w_xstripe) begin
        w_xmin = (r_x > r_ox) ? r_ox : r_x + S9;
        w_xmax = (r_x > r_ox) ? r_x - 9'd1 : r_ox + S1;
      end else if (w_ystripe) begin
        w_ymin = (r_y > r_oy) ? r_oy : r_y + S9;
        w_ymax = (r_y > r_oy) ? r_y - 9'd1 : r_oy + S1;
      end
    end
  end

  // Next window pixel and its rotated ROM address.
  always_comb begin
    w_nc = 9'd0;
    w_nr = 9'd0;
    if (r_state == S_PIX) begin
      w_nc = w_col_end ? 9'd0 : r_c + 9'd1;
      w_nr = w_col_end ? r_r + 9'd1 : r_r;
    end
    case (r_dir)
      2'd1:    begin w_sc = w_nr;      w_sr = S1 - w_nc; end
      2'd2:    begin w_sc = S1 - w_nc; w_sr = w_nr;      end
      2'd3:    begin w_sc = S1 - w_nr; w_sr = w_nc;      end
      default: begin w_sc = w_nc;      w_sr = w_nr;      end
    endcase
    w_addr = AW'(32'(w_sr) * SIZE + 32'(w_sc));
  end

  always_comb begin
    case (r_widx)
      4'd0:    w_win_byte = 8'h2A;
      4'd1:    w_win_byte = {7'b0, r_xmin[8]};
      4'd2:    w_win_byte = r_xmin[7:0];
      4'd3:    w_win_byte = {7'b0, r_xmax[8]};
      4'd4:    w_win_byte = r_xmax[7:0];
      4'd5:    w_win_byte = 8'h2B;
      4'd6:    w_win_byte = {7'b0, r_ymin[8]};
      4'd7:    w_win_byte = r_ymin[7:0];
      4'd8:    w_win_byte = {7'b0, r_ymax[8]};
      4'd9:    w_win_byte = r_ymax[7:0];
      default: w_win_byte = 8'h2C;
    endcase
  end

  assign w_color    = (r_phase && i_rom_bit) ? r_fg : r_bg;
  assign w_pix_byte = 8'(w_color >> (32'd8 * (BPP_BYTES - 32'd1 - 32'(r_bidx))));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    if (i_enable) begin
      case (r_state)
        S_IDLE:  if (i_start) w_nxt_state = S_CALC;
        S_CALC:  w_nxt_state = S_WIN;
        S_WIN:   if (w_ready && w_win_last) w_nxt_state = r_phase ? S_FETCH : S_PIX;
        S_FETCH: w_nxt_state = S_PIX;
        S_PIX: begin
          if (w_ready && w_last_byte) begin
            if (w_pix_done) w_nxt_state = r_phase ? S_FIN : S_CALC;
            else            w_nxt_state = r_phase ? S_FETCH : S_PIX;
          end
        end
        S_FIN:   w_nxt_state = S_IDLE;
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x <= 9'd0;  r_y <= 9'd0;
      r_ox <= 9'(RESET_X);  r_oy <= 9'(RESET_Y);
      r_xmin <= 9'd0;  r_xmax <= 9'd0;  r_ymin <= 9'd0;  r_ymax <= 9'd0;
      r_c <= 9'd0;  r_r <= 9'd0;
      r_dir <= 2'd0;  r_fg <= 24'd0;  r_bg <= 24'd0;
      r_phase <= 1'b0;  r_widx <= 4'd0;  r_bidx <= '0;
      r_frame <= '0;  r_dcnt <= '0;
      r_tft_dc <= 1'b0;  r_tft_data <= 8'd0;  r_tft_transmit <= 1'b0;
      r_busy <= 1'b0;  r_done <= 1'b0;  r_rom_addr <= '0;
`ifdef SPRITE_PINGPONG_EN
      r_fdir <= 1'b0;
`endif
    end else if (!i_enable) begin
      r_tft_transmit <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_tft_transmit <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x <= i_x;  r_y <= i_y;  r_dir <= i_direction;
            r_fg <= i_fg_color;  r_bg <= i_bg_color;
            r_busy <= 1'b1;  r_phase <= 1'b0;
          end
        end
        S_CALC: begin
          r_xmin <= w_xmin;  r_xmax <= w_xmax;  r_ymin <= w_ymin;  r_ymax <= w_ymax;
          r_phase <= r_phase | w_to_draw;
          r_widx <= 4'd0;  r_bidx <= '0;  r_c <= 9'd0;  r_r <= 9'd0;
        end
        S_WIN: begin
          if (w_ready) begin
            r_tft_transmit <= 1'b1;
            r_tft_dc       <= !((r_widx == 4'd0) || (r_widx == 4'd5) || (r_widx == 4'd10));
            r_tft_data     <= w_win_byte;
            r_widx         <= r_widx + 4'd1;
            if (w_win_last && r_phase) r_rom_addr <= w_addr;
          end
        end
        S_PIX: begin
          if (w_ready) begin
            r_tft_transmit <= 1'b1;
            r_tft_dc       <= 1'b1;
            r_tft_data     <= w_pix_byte;
            if (w_last_byte) begin
              r_bidx <= '0;
              r_c    <= w_nc;
              r_r    <= w_nr;
              if (r_phase && !w_pix_done) r_rom_addr <= w_addr;
              if (!r_phase && w_pix_done) r_phase <= 1'b1;
            end else begin
              r_bidx <= r_bidx + BW'(1);
            end
          end
        end
        S_FIN: begin
          r_ox <= r_x;  r_oy <= r_y;
          r_busy <= 1'b0;  r_done <= 1'b1;
          if (r_dcnt == DW'(ANIM_DIV - 1)) begin
            r_dcnt <= '0;
`ifdef SPRITE_PINGPONG_EN
            if (FRAMES > 1) begin
              if (!r_fdir) begin
                if (r_frame == FW'(FRAMES - 1)) begin
                  r_frame <= r_frame - FW'(1);  r_fdir <= 1'b1;
                end else r_frame <= r_frame + FW'(1);
              end else begin
                if (r_frame == '0) begin
                  r_frame <= r_frame + FW'(1);  r_fdir <= 1'b0;
                end else r_frame <= r_frame - FW'(1);
              end
            end
`else
            r_frame <= (r_frame == FW'(FRAMES - 1)) ? '0 : r_frame + FW'(1);
`endif
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rom_frame    = r_frame;
  assign o_rom_addr     = r_rom_addr;
  assign o_tft_dc       = r_tft_dc;
  assign o_tft_data     = r_tft_data;
  assign o_tft_transmit = r_tft_transmit;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: captured TFT byte stream against a pixel-level reference model.
module tb_sprite_blitter;
  localparam int SIZE = 22, FRAMES = 3, BPP = 3, ANIM_DIV = 4;

  logic clk, rst, enable, start, rom_bit, tft_busy;
  logic [8:0] x, y, rom_addr;
  logic [1:0] dir, rom_frame;
  logic [23:0] fg, bg;
  logic tft_dc, tft_transmit, busy, done;
  logic [7:0] tft_data;

  sprite_blitter dut (
    .clk(clk), .rst(rst), .i_enable(enable), .i_start(start), .i_x(x), .i_y(y),
    .i_direction(dir), .i_fg_color(fg), .i_bg_color(bg), .o_rom_frame(rom_frame),
    .o_rom_addr(rom_addr), .i_rom_bit(rom_bit), .i_tft_busy(tft_busy), .o_tft_dc(tft_dc),
    .o_tft_data(tft_data), .o_tft_transmit(tft_transmit), .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rom_mem [FRAMES][SIZE*SIZE];
  always @(posedge clk)
    if (int'(rom_frame) < FRAMES && int'(rom_addr) < SIZE*SIZE) rom_bit <= rom_mem[rom_frame][rom_addr];

  logic hold_busy = 1'b0, rand_busy = 1'b0;
  always @(negedge clk) tft_busy = hold_busy | (rand_busy & ($urandom_range(0, 3) == 0));

  // Byte capture and handshake monitor.
  logic [8:0] cap_q[$];
  int done_cnt = 0, hs_viol = 0;
  logic prev_tx = 1'b0, busy_at_edge = 1'b0;
  always @(posedge clk) busy_at_edge <= tft_busy;
  always @(negedge clk) begin
    if (tft_transmit === 1'b1) begin
      cap_q.push_back({tft_dc, tft_data});
      if (prev_tx || busy_at_edge) hs_viol++;
    end
    if (done === 1'b1) done_cnt++;
    prev_tx = tft_transmit;
  end

  int tests = 0, fails = 0, cap_base = 0;
  int m_ox, m_oy, m_draws;
  logic [8:0] exp_q[$];
  logic [8:0] win_exp [11] = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h11A, 9'h02B,
                               9'h100, 9'h105, 9'h100, 9'h11A, 9'h02C};

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int cap_len();
    return cap_q.size() - cap_base;
  endfunction

  function automatic logic [8:0] cap(input int i);
    if (cap_base + i < cap_q.size()) return cap_q[cap_base + i];
    return 9'h1FF;
  endfunction

  function automatic int exp_frame(input int n);
    int step, period, p;
    step = n / ANIM_DIV;
    period = 2 * (FRAMES - 1);
    p = 0;
`ifdef SPRITE_PINGPONG_EN
    if (FRAMES == 1) return 0;
    p = step % period;
    return (p < FRAMES) ? p : period - p;
`else
    return step % FRAMES + 0 * (period + p);
`endif
  endfunction

  function automatic logic [8:0] dbyte(input int v);
    return 9'(256 | (v & 255));
  endfunction

  task automatic push_win(input int x0, x1, y0, y1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(dbyte(x0 >> 8)); exp_q.push_back(dbyte(x0));
    exp_q.push_back(dbyte(x1 >> 8)); exp_q.push_back(dbyte(x1));
    exp_q.push_back(9'h02B);
    exp_q.push_back(dbyte(y0 >> 8)); exp_q.push_back(dbyte(y0));
    exp_q.push_back(dbyte(y1 >> 8)); exp_q.push_back(dbyte(y1));
    exp_q.push_back(9'h02C);
  endtask

  task automatic push_color(input logic [23:0] c);
    for (int k = BPP - 1; k >= 0; k--) exp_q.push_back(dbyte(int'(c >> (8 * k))));
  endtask

  // Reference: erase rectangle from the old/new positions, then the rotated sprite.
  task automatic build_exp(input int nx, ny, nd, input logic [23:0] f, b);
    int x0, x1, y0, y1, fr, sc, sr, adx, ady;
    exp_q.delete();
    fr = exp_frame(m_draws);
    adx = (nx > m_ox) ? nx - m_ox : m_ox - nx;
    ady = (ny > m_oy) ? ny - m_oy : m_oy - ny;
    if (!(nx == m_ox && ny == m_oy)) begin
      x0 = m_ox; x1 = m_ox + SIZE - 1; y0 = m_oy; y1 = m_oy + SIZE - 1;
      if (ny == m_oy && adx < SIZE) begin
        if (nx > m_ox) begin x0 = m_ox; x1 = nx - 1; end
        else begin x0 = nx + SIZE; x1 = m_ox + SIZE - 1; end
      end else if (nx == m_ox && ady < SIZE) begin
        if (ny > m_oy) begin y0 = m_oy; y1 = ny - 1; end
        else begin y0 = ny + SIZE; y1 = m_oy + SIZE - 1; end
      end
      push_win(x0, x1, y0, y1);
      repeat ((x1 - x0 + 1) * (y1 - y0 + 1)) push_color(b);
    end
    push_win(nx, nx + SIZE - 1, ny, ny + SIZE - 1);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        case (nd)
          1:       begin sc = r;            sr = SIZE - 1 - c; end
          2:       begin sc = SIZE - 1 - c; sr = r;            end
          3:       begin sc = SIZE - 1 - r; sr = c;            end
          default: begin sc = c;            sr = r;            end
        endcase
        push_color(rom_mem[fr][sr * SIZE + sc] ? f : b);
      end
  endtask

  // mode 0: plain, 1: tft_busy held 50 cycles, 2: enable low 20 cycles (after `after` bytes).
  task automatic run_op(input string tag, input int nx, ny, nd, input logic [23:0] f, b,
                        input int mode, input int after);
    int d0, h0, n0, n1, mism;
    bit disturbed;
    build_exp(nx, ny, nd, f, b);
    cap_base = cap_q.size(); d0 = done_cnt; h0 = hs_viol; disturbed = 0;
    x = 9'(nx); y = 9'(ny); dir = 2'(nd); fg = f; bg = b; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
    chk({tag, "_frame"}, 32'(rom_frame), 32'(exp_frame(m_draws)));
    for (int t = 0; t < 20000 && done_cnt == d0; t++) begin
      if (t == 100) begin
        x = 9'd0; y = 9'd0; start = 1'b1; tick(); start = 1'b0;
      end
      if (mode != 0 && !disturbed && cap_len() >= after) begin
        disturbed = 1;
        if (mode == 1) hold_busy = 1'b1; else enable = 1'b0;
        tick();
        n0 = cap_q.size();
        tick((mode == 1) ? 49 : 19);
        n1 = cap_q.size();
        hold_busy = 1'b0; enable = 1'b1;
        chk({tag, "_stall_strobes"}, 32'(n1), 32'(n0));
      end
      tick();
    end
    tick(4);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
    chk({tag, "_len"}, 32'(cap_len()), 32'(exp_q.size()));
    mism = 0;
    foreach (exp_q[i]) if (cap(i) !== exp_q[i]) mism++;
    chk({tag, "_data_mism"}, 32'(mism), 32'd0);
    chk({tag, "_handshake"}, 32'(hs_viol - h0), 32'd0);
    m_ox = nx; m_oy = ny; m_draws++;
  endtask

  function automatic int near(input int v);
    int d, r;
    d = $urandom_range(1, SIZE - 1);
    r = ($urandom_range(0, 1) == 1) ? v + d : v - d;
    if (r < 0) r = v + d;
    if (r > 319 - SIZE + 1) r = v - d;
    return r;
  endfunction

  initial begin
    int n0, d0, rx, ry, kind;
    logic [23:0] cf, cb;
    rst = 1'b0; enable = 1'b1; start = 1'b0; x = '0; y = '0; dir = '0; fg = '0; bg = '0;
    for (int f = 0; f < FRAMES; f++)
      for (int i = 0; i < SIZE * SIZE; i++) rom_mem[f][i] = 1'($urandom_range(0, 1));
    tick(3);
    chk("rst_transmit", 32'(tft_transmit), 0);
    chk("rst_dc", 32'(tft_dc), 0);
    chk("rst_data", 32'(tft_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_rom_frame", 32'(rom_frame), 0);
    rst = 1'b1;
    tick(2);
    m_ox = 5; m_oy = 5; m_draws = 0;

    cf = 24'($urandom); cb = 24'($urandom);
    run_op("first", 5, 5, 0, cf, cb, 0, 0);
    chk("first_count", 32'(cap_len()), 32'd1463);
    for (int i = 0; i < 11; i++) chk($sformatf("first_win%0d", i), 32'(cap(i)), 32'(win_exp[i]));

    run_op("xstripe", 7, 5, $urandom_range(0, 3), 24'($urandom), cb, 0, 0);
    chk("xstripe_count", 32'(cap_len()), 32'd1606);
    chk("xstripe_xmin", 32'(cap(2)), 32'h105);
    chk("xstripe_xmax", 32'(cap(4)), 32'h106);
    chk("xstripe_ymax", 32'(cap(9)), 32'h11A);

    run_op("full", 40, 60, $urandom_range(0, 3), 24'($urandom), 24'($urandom), 0, 0);
    chk("full_count", 32'(cap_len()), 32'd2926);

    for (int f = 0; f < FRAMES; f++)
      for (int i = 0; i < SIZE * SIZE; i++) rom_mem[f][i] = (i == 0);
    cf = 24'hA1B2C3; cb = 24'h102030;
    run_op("rot", 40, 60, 1, cf, cb, 0, 0);
    chk("rot_fg_b0", 32'(cap(74)), 32'h1A1);
    chk("rot_fg_b2", 32'(cap(76)), 32'h1C3);
    chk("rot_bg_prev", 32'(cap(71)), 32'h110);
    chk("rot_bg_next", 32'(cap(77)), 32'h110);
    for (int f = 0; f < FRAMES; f++)
      for (int i = 0; i < SIZE * SIZE; i++) rom_mem[f][i] = 1'($urandom_range(0, 1));

    run_op("hold", 40, 62, 2, 24'($urandom), 24'($urandom), 1, 200);
    chk("hold_count", 32'(cap_len()), 32'(143 + 1463));

    kind = $urandom_range(0, 2);
    rx = (kind == 1) ? m_ox : (kind == 0) ? near(m_ox) : $urandom_range(0, 298);
    ry = (kind == 0) ? m_oy : (kind == 1) ? near(m_oy) : $urandom_range(0, 298);
    rand_busy = 1'b1;
    run_op("rand", rx, ry, $urandom_range(0, 3), 24'($urandom), 24'($urandom), 2,
           $urandom_range(20, 1400));
    rand_busy = 1'b0;

    // Reset in the middle of pixel output.
    cap_base = cap_q.size(); d0 = done_cnt;
    x = 9'd100; y = 9'd100; dir = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 5000 && cap_len() < 300; t++) tick();
    chk("rstmid_reached", 32'(cap_len() >= 300), 1);
    rst = 1'b0;
    tick();
    chk("rstmid_transmit", 32'(tft_transmit), 0);
    chk("rstmid_busy", 32'(busy), 0);
    n0 = cap_q.size();
    tick(2);
    rst = 1'b1;
    tick(200);
    chk("rstmid_no_strobes", 32'(cap_q.size()), 32'(n0));
    chk("rstmid_no_done", 32'(done_cnt), 32'(d0));
    chk("rstmid_frame", 32'(rom_frame), 0);
    m_ox = 5; m_oy = 5; m_draws = 0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("anim%0d", i), 5, 5, i % 4, 24'($urandom), 24'($urandom), 0, 0);
    chk("anim_after12", 32'(rom_frame), 32'(exp_frame(12)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Parametrised successor to the fixed 22x22 player drawer.
- Draws an animated, rotatable SIZE x SIZE sprite on the 8-bit TFT command/data bus.
- On each move, first erases only the part of the old footprint that the new one does not cover, then draws the new footprint.
- Sprite bitmaps come from an external 1-bit ROM with 1-cycle read latency. Sits between game logic (start/x/y/direction) and the TFT arbiter.

Parameters:
- SIZE, 22: sprite edge in pixels.
- FRAMES, 3: animation frames in the ROM (>=1).
- BPP_BYTES, 3: bytes sent per pixel, MSB first (3 = RGB666 on a 24-bit colour input).
- ANIM_DIV, 4: completed draws per animation frame step.
- RESET_X, 5: initial "old" x.
- RESET_Y, 5: initial "old" y.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- enable  in  1  clock enable; when low, all state holds and tft_transmit is forced 0
- start  in  1  request draw at x/y; sampled only in IDLE
- x  in  9  new top-left column
- y  in  9  new top-left row
- direction  in  2  0 right, 1 down, 2 left, 3 up
- fg_color  in  24  colour for sprite bit 1
- bg_color  in  24  colour for sprite bit 0 and for erase
- rom_frame  out  $clog2(FRAMES)  frame select
- rom_addr  out  $clog2(SIZE*SIZE)  bit index, sr*SIZE+sc
- rom_bit  in  1  ROM data, valid 1 cycle after address
- tft_busy  in  1  bus busy
- tft_dc  out  1  0 command, 1 data
- tft_data  out  8  byte
- tft_transmit  out  1  one-cycle byte strobe
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on completion

Behaviour:
- Interface: reset rst, synchronous, active-low; clock clk.
- Reset values: tft_transmit=0, tft_dc=0, tft_data=0, busy=0, done=0, rom_addr=0, rom_frame=0. Old position = (RESET_X, RESET_Y); frame=0; draw counter=0.
- Reset mid-operation aborts immediately: no further strobes and no done pulse.
- Byte handshake: a byte is issued only when tft_busy=0 and tft_transmit=0. tft_transmit is high for exactly one cycle per byte, so consecutive bytes are at least 2 cycles apart.
- FSM states: IDLE, CALC, WIN, FETCH, PIX, FIN.
- IDLE:
  - On start: latch x, y, direction, fg_color, bg_color; busy<=1 next cycle; go to CALC.
  - start while busy is ignored.
- CALC (1 cycle): select the phase rectangle [xmin..xmax, ymin..ymax].
  - Erase phase, with old position (ox,oy) and new position (x,y):
    - New equals old: no erase; go straight to the draw phase.
    - y==oy and 0<|x-ox|<SIZE: erase a column stripe, [ox..x-1] if x>ox, else [x+SIZE..ox+SIZE-1]; rows oy..oy+SIZE-1.
    - x==ox and 0<|y-oy|<SIZE: symmetric row stripe.
    - Any other case: erase the full old box.
  - Draw phase: the full new box.
  - All arithmetic is 9-bit; the caller guarantees x+SIZE-1 and y+SIZE-1 are <=319.
- WIN: send 11 bytes in order:
  - cmd 0x2A; data {7'b0,xmin[8]}, xmin[7:0], {7'b0,xmax[8]}, xmax[7:0];
  - cmd 0x2B; the same four bytes for ymin/ymax;
  - cmd 0x2C.
- FETCH (draw phase only): drive rom_addr for window pixel (c,r) and wait 1 cycle. Source coordinates:
  - dir0: (sc,sr)=(c,r)
  - dir1: (r, SIZE-1-c)
  - dir2: (SIZE-1-c, r)
  - dir3: (SIZE-1-r, c)
- PIX: send BPP_BYTES data bytes of the selected colour, MSB byte first.
  - Erase phase always uses bg_color and skips FETCH.
  - Draw phase uses fg_color if rom_bit=1, else bg_color.
  - Pixels are raster ordered, c fastest.
  - After the last pixel, the erase phase returns to CALC to start the draw phase; the draw phase goes to FIN.
- FIN (1 cycle):
  - old position <= (x,y); done=1; busy<=0.
  - Draw counter increments. When it reaches ANIM_DIV-1, it clears and the frame advances: FRAMES-1 wraps to 0.
  - rom_frame = current frame throughout the draw phase.
- Byte totals:
  - Full box: 11 + SIZE*SIZE*BPP_BYTES (1463 at defaults).
  - Stripe of width w: 11 + w*SIZE*BPP_BYTES.

Optional Feature:
- Macro: SPRITE_PINGPONG_EN.
- Defined: the frame sequence bounces 0,1,..,FRAMES-1,FRAMES-2,..,1,0,1,... using a direction flag (reset: ascending). With FRAMES=1 the frame stays 0.
- Undefined: the frame wraps FRAMES-1 -> 0; no flag register exists.

Test Plan:
- Reset, then start at (5,5), dir0, tft_busy=0: no erase; exactly 1463 strobes; window bytes 2A,00,05,00,1A,2B,00,05,00,1A,2C; then done pulses once.
- From (5,5), start at (7,5): erase window x 5..6, y 5..26 = 11+132 bytes, all bg_color; then draw window x 7..28 = 1463 bytes.
- Start at (40,60) from (7,5): full old box erased (1463 bytes), then new box drawn; 2926 strobes total.
- Single set ROM bit at index 0, direction=1: the fg_color pixel appears at window (c=SIZE-1, r=0), i.e. data byte position (21)*3+11.
- tft_busy held high 50 cycles mid-pixel: no strobe while high; sequence resumes with no byte lost or duplicated. rst low mid-PIX: tft_transmit=0 and busy=0 the next cycle.
- 12 consecutive draws with defaults: frames 0,0,0,0,1,1,1,1,2,2,2,2 wrap to 0. With SPRITE_PINGPONG_EN and 16 draws: the frame goes 0,1,2,1.
